// File: rtl/elf_pkg.sv
// Shared types for the ELF main-RAM arbiter: FSM state, grant source and RAM geometry.
package elf_pkg;

    localparam int RAM_ADDR_W = 12;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_LOAD = 2'd1,
        G_DMA  = 2'd2,
        G_CPU  = 2'd3
    } grant_t;

endpackage

// File: rtl/elf_load_buffer.sv
// One-entry holding register between the ioctl download port and the RAM.
// Drops out-of-range bytes and back-pressures the host while occupied.
module elf_load_buffer #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture_en,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              drain,
    output logic              buf_valid,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic              ioctl_wait
);

    logic in_range;
    logic capture;

    assign in_range = (ioctl_addr >> ADDR_W) == 25'd0;
    assign capture  = capture_en && ioctl_wr && in_range && !buf_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= 8'd0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            buf_addr  <= ioctl_addr[ADDR_W-1:0];
            buf_data  <= ioctl_dout;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

    assign ioctl_wait = buf_valid;

    // The host must honour ioctl_wait; a strobe landing on a full buffer is lost.
    host_wr_while_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(capture_en && ioctl_wr && buf_valid));

endmodule

// File: rtl/elf_ram_arbiter.sv
// Single-port ELF main RAM sequencer: loader, Pixie DMA and 1802 CPU share one
// access slot per cycle; download mode locks out DMA and CPU until the buffer drains.
module elf_ram_arbiter
    import elf_pkg::*;
#(
    parameter int         ADDR_W       = RAM_ADDR_W,
    parameter logic [7:0] LOAD_INDEX   = 8'd0,
    parameter int         CPU_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              load_busy,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output arb_state_t        dbg_state
);

    localparam int CNT_W = $clog2(CPU_MAX_WAIT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    grant_t            grant;
    logic [CNT_W-1:0]  starve_cnt;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              capture_en;
    logic              run_en;
    logic [7:0]        cpu_rdata_q;
    logic [7:0]        dma_rdata_q;

    elf_load_buffer #(.ADDR_W(ADDR_W)) u_load_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .capture_en (capture_en),
        .ioctl_wr   (ioctl_wr),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .drain      (grant == G_LOAD),
        .buf_valid  (buf_valid),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .ioctl_wait (ioctl_wait)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (ioctl_download && ioctl_index == LOAD_INDEX) state_nxt = S_LOAD;
            S_LOAD:  if (!ioctl_download) state_nxt = S_FLUSH;
            S_FLUSH: if (!buf_valid) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        load_busy  = (state != S_RUN);
        capture_en = (state == S_LOAD);
        run_en     = (state == S_RUN);
    end

    // Handshake: req is sampled at a clock edge and held by the requester until
    // it sees ack in the following cycle; a req still high at the next edge is a
    // new request. Read data follows one cycle after ack, with rvalid for one cycle.
    always_comb begin
        grant = G_NONE;
        if (buf_valid) begin
            grant = G_LOAD;
        end else if (run_en) begin
            if (cpu_req && (!dma_req || starve_cnt == CNT_W'(CPU_MAX_WAIT))) grant = G_CPU;
            else if (dma_req) grant = G_DMA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= 8'd0;
            cpu_rvalid  <= 1'b0;
            dma_rvalid  <= 1'b0;
            cpu_rdata_q <= 8'd0;
            dma_rdata_q <= 8'd0;
            starve_cnt  <= '0;
        end else begin
            cpu_ack <= (grant == G_CPU);
            dma_ack <= (grant == G_DMA);
            ram_we  <= (grant == G_LOAD) || (grant == G_CPU && cpu_we);
            case (grant)
                G_LOAD: begin
                    ram_addr  <= buf_addr;
                    ram_wdata <= buf_data;
                end
                G_DMA:  ram_addr <= dma_addr;
                G_CPU: begin
                    ram_addr  <= cpu_addr;
                    ram_wdata <= cpu_wdata;
                end
                default: ;
            endcase
            cpu_rvalid <= cpu_ack && !ram_we;
            dma_rvalid <= dma_ack;
            if (cpu_rvalid) cpu_rdata_q <= ram_rdata;
            if (dma_rvalid) dma_rdata_q <= ram_rdata;
            if (!cpu_req || grant == G_CPU) starve_cnt <= '0;
            else if (grant == G_DMA)        starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // The RAM output register is the read pipeline stage; the _q copies only hold data between reads.
    assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
    assign dma_rdata = dma_rvalid ? ram_rdata : dma_rdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_elf_ram_arbiter.sv
// Directed and randomized checks of elf_ram_arbiter against a transaction-level
// model of the arbitration rules and a reference copy of RAM contents.
module tb_elf_ram_arbiter;
    import elf_pkg::*;

    localparam int CPU_MAX_WAIT = 4;

    logic        clk;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        load_busy;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        dma_req;
    logic [11:0] dma_addr;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    arb_state_t  dbg_state;

    elf_ram_arbiter #(.ADDR_W(12), .LOAD_INDEX(8'd0), .CPU_MAX_WAIT(CPU_MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .load_busy(load_busy),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM macro model
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Scoreboard state
    logic [7:0] ref_mem [0:4095];
    int n_cmp  = 0;
    int n_fail = 0;

    // Arbitration model: consecutive cycles the CPU has lost, and last cycle's winner
    int         m_losses = 0;
    int         m_prev_w = 0;
    logic       m_prev_we = 1'b0;
    logic [7:0] m_prev_c = 8'd0;
    logic [7:0] m_prev_d = 8'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_access(input logic we, input logic [11:0] a, input logic [7:0] d, input string tag);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        check({tag, "_ack"}, cpu_ack, 1);
        check({tag, "_dma_ack"}, dma_ack, 0);
        check({tag, "_ram_we"}, ram_we, we);
        check({tag, "_ram_addr"}, ram_addr, a);
        if (we) begin
            check({tag, "_ram_wdata"}, ram_wdata, d);
            ref_mem[a] = d;
        end
        tick();
        check({tag, "_rvalid"}, cpu_rvalid, !we);
        if (!we) check({tag, "_rdata"}, cpu_rdata, ref_mem[a]);
        tick();
        check({tag, "_rvalid_end"}, cpu_rvalid, 0);
        if (!we) check({tag, "_rdata_hold"}, cpu_rdata, ref_mem[a]);
    endtask

    task automatic dma_read(input logic [11:0] a);
        dma_req = 1'b1; dma_addr = a;
        tick();
        dma_req = 1'b0;
        check("dma_ack", dma_ack, 1);
        check("dma_cpu_ack", cpu_ack, 0);
        check("dma_ram_we", ram_we, 0);
        tick();
        check("dma_rvalid", dma_rvalid, 1);
        check("dma_rdata", dma_rdata, ref_mem[a]);
        tick();
        check("dma_rdata_hold", dma_rdata, ref_mem[a]);
    endtask

    // One download strobe; the caller has already entered load mode.
    task automatic load_byte(input logic [24:0] a, input logic [7:0] d, input logic drop_after);
        logic in_range;
        in_range = (a < 25'h1000);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
        if (drop_after) ioctl_download = 1'b0;
        check("load_wait_high", ioctl_wait, in_range);
        check("load_cpu_ack", cpu_ack, 0);
        check("load_dma_ack", dma_ack, 0);
        tick();
        check("load_wait_low", ioctl_wait, 0);
        check("load_ram_we", ram_we, in_range);
        if (in_range) begin
            check("load_ram_addr", ram_addr, a[11:0]);
            check("load_ram_wdata", ram_wdata, d);
            ref_mem[a[11:0]] = d;
        end
        check("load_cpu_ack2", cpu_ack, 0);
    endtask

    // One arbitration cycle of random addresses against the rule-level model.
    task automatic arb_cycle(input logic cr, input logic dr, input logic cw);
        logic [11:0] ca;
        logic [11:0] da;
        logic [7:0]  cd;
        logic [7:0]  ec;
        logic [7:0]  ed;
        int w;
        ca = 12'h100 + 12'($urandom_range(0, 63));
        da = 12'h100 + 12'($urandom_range(0, 63));
        cd = 8'($urandom_range(0, 255));
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_addr = da;
        if (cr && (m_losses == CPU_MAX_WAIT || !dr)) w = 2;
        else if (dr) w = 1;
        else w = 0;
        if (!cr || w == 2) m_losses = 0;
        else if (w == 1) m_losses++;
        ec = ref_mem[ca];
        ed = ref_mem[da];
        if (w == 2 && cw) ref_mem[ca] = cd;
        tick();
        check("arb_cpu_ack", cpu_ack, (w == 2));
        check("arb_dma_ack", dma_ack, (w == 1));
        check("arb_cpu_rvalid", cpu_rvalid, (m_prev_w == 2 && !m_prev_we));
        if (m_prev_w == 2 && !m_prev_we) check("arb_cpu_rdata", cpu_rdata, m_prev_c);
        check("arb_dma_rvalid", dma_rvalid, (m_prev_w == 1));
        if (m_prev_w == 1) check("arb_dma_rdata", dma_rdata, m_prev_d);
        m_prev_w = w; m_prev_we = cw; m_prev_c = ec; m_prev_d = ed;
    endtask

    logic [11:0] dl_addr_q[$];
    logic [7:0]  d8;

    initial begin
        ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = 8'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'd0;
        dma_req = 1'b0; dma_addr = '0;
        reset_n = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dma_ack", dma_ack, 0);
        check("rst_dma_rvalid", dma_rvalid, 0);
        check("rst_dma_rdata", dma_rdata, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_ioctl_wait", ioctl_wait, 0);
        check("rst_load_busy", load_busy, 0);
        check("rst_state", dbg_state, S_RUN);
        reset_n = 1'b1;
        tick();

        // Basic CPU write then read of 0x010
        cpu_access(1'b1, 12'h010, 8'h5A, "cpu_wr010");
        cpu_access(1'b0, 12'h010, 8'h00, "cpu_rd010");

        // Fill the random-access window, then spot-check reads
        for (int i = 0; i < 64; i++)
            cpu_access(1'b1, 12'h100 + 12'(i), 8'($urandom_range(0, 255)), "fill");
        for (int i = 0; i < 8; i++) begin
            cpu_access(1'b0, 12'h100 + 12'($urandom_range(0, 63)), 8'h00, "cpu_rd");
            dma_read(12'h100 + 12'($urandom_range(0, 63)));
        end

        // Sustained contention: four DMA slots then one CPU slot, every cycle granted
        m_losses = 0; m_prev_w = 0;
        for (int c = 0; c < 20; c++) begin
            arb_cycle(1'b1, 1'b1, 1'b0);
            check("stream_cpu_slot", cpu_ack, (c % 5) == 4);
            check("stream_any_ack", cpu_ack | dma_ack, 1);
        end
        arb_cycle(1'b0, 1'b0, 1'b0);

        // Randomized request mix including CPU writes
        for (int c = 0; c < 300; c++)
            arb_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
        arb_cycle(1'b0, 1'b0, 1'b0);
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();

        // Download index 0 with the CPU requesting throughout
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick();
        check("dl_busy", load_busy, 1);
        check("dl_state", dbg_state, S_LOAD);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h100;
        tick();
        check("dl_cpu_held", cpu_ack, 0);
        load_byte(25'd0, 8'hC4, 1'b0);
        load_byte(25'd1, 8'h30, 1'b0);
        load_byte(25'd2, 8'h00, 1'b0);
        ioctl_download = 1'b0;
        tick();
        check("flush_busy", load_busy, 1);
        check("flush_state", dbg_state, S_FLUSH);
        check("flush_cpu_ack", cpu_ack, 0);
        tick();
        check("flush_done_busy", load_busy, 0);
        check("flush_done_cpu_ack", cpu_ack, 0);
        tick();
        check("post_load_cpu_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        tick();
        check("post_load_rvalid", cpu_rvalid, 1);
        check("post_load_rdata", cpu_rdata, ref_mem[12'h100]);
        tick();
        cpu_access(1'b0, 12'h000, 8'h00, "dl_rd0");
        cpu_access(1'b0, 12'h001, 8'h00, "dl_rd1");
        cpu_access(1'b0, 12'h002, 8'h00, "dl_rd2");
        d8 = ref_mem[12'h002];
        check("dl_byte2_value", d8, 8'h00);

        // Out-of-range strobe, then a final strobe with download falling right after
        ioctl_download = 1'b1;
        tick();
        load_byte(25'h1000, 8'($urandom_range(0, 255)), 1'b0);
        tick();
        check("oor_no_we", ram_we, 0);
        d8 = 8'($urandom_range(0, 255));
        load_byte(25'd3, d8, 1'b1);
        check("fall_flush_busy", load_busy, 1);
        tick();
        check("fall_run", load_busy, 0);
        check("fall_state", dbg_state, S_RUN);
        cpu_access(1'b0, 12'h003, 8'h00, "fall_rd3");

        // Download to a non-RAM index leaves the arbiter in run mode
        ioctl_index = 8'd1; ioctl_download = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h120;
        tick();
        cpu_req = 1'b0;
        check("idx1_state", dbg_state, S_RUN);
        check("idx1_busy", load_busy, 0);
        check("idx1_cpu_ack", cpu_ack, 1);
        ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'hEE;
        tick();
        ioctl_wr = 1'b0;
        check("idx1_no_we", ram_we, 0);
        check("idx1_no_wait", ioctl_wait, 0);
        check("idx1_rvalid", cpu_rvalid, 1);
        check("idx1_rdata", cpu_rdata, ref_mem[12'h120]);
        tick();
        check("idx1_no_we2", ram_we, 0);
        check("idx1_wait2", ioctl_wait, 0);
        ioctl_download = 1'b0; ioctl_index = 8'd0;
        tick();

        // Randomized download, including occasional out-of-range addresses
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            logic [24:0] a;
            if ($urandom_range(0, 3) == 0) a = 25'h1000 + 25'($urandom_range(0, 4095));
            else begin
                a = 25'h140 + 25'($urandom_range(0, 63));
                dl_addr_q.push_back(a[11:0]);
            end
            load_byte(a, 8'($urandom_range(0, 255)), 1'b0);
        end
        ioctl_download = 1'b0;
        tick(); tick();
        check("rnd_dl_run", load_busy, 0);
        while (dl_addr_q.size() > 0) cpu_access(1'b0, dl_addr_q.pop_front(), 8'h00, "rnd_dl_rd");

        // Reset in the middle of a download with a byte buffered
        ioctl_download = 1'b1;
        tick();
        ioctl_wr = 1'b1; ioctl_addr = 25'h180; ioctl_dout = 8'h77;
        tick();
        ioctl_wr = 1'b0;
        check("mid_wait", ioctl_wait, 1);
        check("mid_busy", load_busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", load_busy, 0);
        check("mid_rst_wait", ioctl_wait, 0);
        check("mid_rst_state", dbg_state, S_RUN);
        check("mid_rst_we", ram_we, 0);
        ioctl_download = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_we", ram_we, 0);
        check("post_rst_busy", load_busy, 0);
        cpu_access(1'b0, 12'h003, 8'h00, "post_rst_rd3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/elf_ram_arbiter.md
Name: elf_ram_arbiter

Overview:
- Sequences all access to the single-port ELF main RAM.
- Shares it between three requesters: the ioctl ROM/program loader, Pixie video DMA, and the 1802 CPU bus.
- Owns load mode: holds off the CPU during download, buffers loader writes and back-pressures the host through ioctl_wait.
- Sits inside cosmacelf between the ioctl interface, CPU, video DMA and the RAM macro (synchronous read, 1-cycle latency).

Parameters:
ADDR_W, 12, RAM address width (4 KiB).
LOAD_INDEX, 8'd0, ioctl_index value whose writes target RAM.
CPU_MAX_WAIT, 4, consecutive cycles the CPU may lose to DMA before it is forced one slot.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
ioctl_download  in  1  host download active
ioctl_index  in  8  download target select
ioctl_wr  in  1  write strobe, one cycle
ioctl_addr  in  25  download byte address
ioctl_dout  in  8  download byte
ioctl_wait  out  1  host must not strobe while high
load_busy  out  1  high in S_LOAD/S_FLUSH
cpu_req  in  1  CPU access request, held until ack
cpu_we  in  1  1 = write
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle grant pulse
cpu_rdata  out  8  read data
cpu_rvalid  out  1  cpu_rdata valid, one cycle
dma_req  in  1  DMA read request, held until ack
dma_addr  in  ADDR_W  DMA address
dma_ack  out  1  one-cycle grant pulse
dma_rdata  out  8  DMA read data
dma_rvalid  out  1  dma_rdata valid, one cycle
ram_addr  out  ADDR_W  registered RAM address
ram_we  out  1  registered RAM write enable
ram_wdata  out  8  registered RAM write data
ram_rdata  in  8  RAM read data, valid 1 cycle after ram_addr

Behaviour:
- Reset: all outputs 0, state S_RUN, load buffer empty, starve counter 0.
- FSM S_RUN / S_LOAD / S_FLUSH:
  - S_RUN -> S_LOAD when ioctl_download=1 and ioctl_index==LOAD_INDEX.
  - S_LOAD -> S_FLUSH when ioctl_download falls.
  - S_FLUSH -> S_RUN once the buffer is empty. If the buffer is already empty when download falls, S_FLUSH lasts 1 cycle.
- Load buffer: 1 entry.
  - ioctl_wr in S_LOAD with ioctl_addr < 2**ADDR_W captures {addr[ADDR_W-1:0], data}.
  - Out-of-range addresses are dropped silently.
  - ioctl_wait = buffer valid, registered.
  - A strobe while the buffer is full is dropped; this is a host protocol violation and is checked by an assertion.
  - Buffer drains on the cycle after capture: ram_we=1.
- In S_LOAD/S_FLUSH: dma_ack=0 and cpu_ack=0; requests stay pending.
- Arbitration in S_RUN, one grant per cycle:
  - DMA beats CPU.
  - If starve counter == CPU_MAX_WAIT and cpu_req=1, CPU wins and the counter clears.
  - Counter increments when cpu_req=1 and DMA wins; clears on any CPU grant or when cpu_req=0.
- Timing: request sampled at edge N.
  - ack pulses and ram_* are driven during cycle N+1.
  - rdata/rvalid for reads appear in cycle N+2; ram_rdata is registered into the winner's rdata.
- Back-to-back: a requester holding req after ack is granted again, subject to priority, so a sustained stream of 1 access/cycle is possible.
- CPU writes: cpu_rvalid is not asserted.
- Rdata holds its value until the next valid.
- Reset mid-operation: asynchronous clear; in-flight rvalid is lost and the buffer is discarded.

Decomposition:
- Package elf_pkg: arb_state_t enum, grant_t enum {G_NONE, G_LOAD, G_DMA, G_CPU}, RAM_ADDR_W constant.
- One sub-module, elf_load_buffer: 1-entry capture/drain buffer with range check and ioctl_wait generation.

Test Plan:
- Reset, CPU read of addr 0x010 holding 0x5A -> cpu_ack at N+1, cpu_rvalid with cpu_rdata=0x5A at N+2; dma_ack stays 0.
- dma_req and cpu_req asserted continuously, CPU_MAX_WAIT=4 -> four dma_ack, one cpu_ack, pattern repeats; no cycle without an ack.
- Download index 0, bytes 0xC4,0x30,0x00 to addresses 0..2 with cpu_req held -> RAM[0..2] written in order, ioctl_wait pulses after each strobe, cpu_ack=0 until S_RUN.
- Download write at ioctl_addr 0x1000 with ADDR_W=12 -> no ram_we, ioctl_wait stays 0.
- Download index 1 -> state stays S_RUN, no RAM writes, CPU still acked.
- ioctl_download falls the cycle after the final strobe -> S_FLUSH drains the last byte, then S_RUN; reset_n low mid-download clears load_busy and ioctl_wait immediately.
